// File: rtl/biquad_pkg.sv
// Shared constants for the biquad coefficient sequencer: coefficient slot
// indices, stored/streamed word counts and FSM state encoding.
package biquad_pkg;

  localparam logic [2:0] IDX_A1  = 3'd0;
  localparam logic [2:0] IDX_A2  = 3'd1;
  localparam logic [2:0] IDX_B0  = 3'd2;
  localparam logic [2:0] IDX_B1  = 3'd3;
  localparam logic [2:0] IDX_B2  = 3'd4;
  localparam logic [2:0] IDX_ONE = 3'd5;

  localparam int NCOEF_STORED = 5;
  localparam int NCOEF_SEQ    = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/coef_bank_dbuf.sv
// Shadow/active coefficient storage. Writes go to shadow; copy moves the whole
// shadow bank to active in one edge. Read port returns the unity word for IDX_ONE.
module coef_bank_dbuf
  import biquad_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int FRAC  = 14,
  parameter int NSEC  = 2,
  parameter int SECW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [SECW-1:0]  wr_sec,
  input  logic [2:0]       wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             copy,
  input  logic             rd_shadow,
  input  logic [SECW-1:0]  rd_sec,
  input  logic [2:0]       rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  logic [NSEC-1:0][NCOEF_STORED-1:0][WIDTH-1:0] shadow_w;
  logic [NSEC-1:0][NCOEF_STORED-1:0][WIDTH-1:0] active_w;

  for (genvar s = 0; s < NSEC; s++) begin : g_sec
    for (genvar k = 0; k < NCOEF_STORED; k++) begin : g_coef
      // identity section: b0 = ONE, everything else zero
      localparam logic [WIDTH-1:0] INIT = (k == int'(IDX_B0)) ? ONE : '0;
      logic [WIDTH-1:0] sh_q;
      logic [WIDTH-1:0] act_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          sh_q  <= INIT;
          act_q <= INIT;
        end else begin
          if (wr_en && (wr_sec == SECW'(s)) && (wr_idx == 3'(k)))
            sh_q <= wr_data;
          if (copy)
            act_q <= sh_q;
        end
      end

      assign shadow_w[s][k] = sh_q;
      assign active_w[s][k] = act_q;
    end
  end

  // rd_shadow lets a run starting in the copy cycle see the incoming bank
  always_comb begin
    rd_data = '0;
    if (rd_idx == IDX_ONE) begin
      rd_data = ONE;
    end else begin
      for (int s = 0; s < NSEC; s++)
        for (int k = 0; k < NCOEF_STORED; k++)
          if ((rd_sec == SECW'(s)) && (rd_idx == 3'(k)))
            rd_data = rd_shadow ? shadow_w[s][k] : active_w[s][k];
    end
  end

endmodule

// File: rtl/biquad_coef_sequencer.sv
// Streams NSEC x 6 coefficient words (a1,a2,b0,b1,b2,ONE per section) per start
// pulse from a double-buffered bank; commits apply only while idle.
module biquad_coef_sequencer
  import biquad_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int FRAC  = 14,
  parameter int NSEC  = 2,
  parameter int SECW  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    wr_en,
  input  logic [SECW-1:0]         wr_sec,
  input  logic [2:0]              wr_idx,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    commit,
  output logic                    busy,
  output logic                    coef_valid,
  output logic [SECW-1:0]         coef_sec,
  output logic [2:0]              coef_idx,
  output logic signed [WIDTH-1:0] coef,
  output logic                    done,
  output logic                    commit_pending,
  output logic                    wr_err
);

  localparam logic [SECW-1:0] LAST_SEC = SECW'(NSEC - 1);
  localparam logic [SECW:0]   NSEC_W   = (SECW + 1)'(NSEC);

  if ((NSEC < 1) || (NSEC > 8) || ((1 << SECW) < NSEC)) begin : g_param_chk
    $error("biquad_coef_sequencer: NSEC must be 1..8 and fit in SECW bits");
  end

  state_t          state, nxt_state;
  logic [SECW-1:0] sec_q, nxt_sec;
  logic [2:0]      idx_q, nxt_idx;
  logic            nxt_vld, nxt_done;
  logic            pending_q;
  logic            copy, wr_ok;
  logic [WIDTH-1:0] rd_data;

  assign wr_ok = ({1'b0, wr_sec} < NSEC_W) && (wr_idx <= IDX_B2);
  assign copy  = (state == ST_IDLE) && pending_q;

  coef_bank_dbuf #(
    .WIDTH(WIDTH), .FRAC(FRAC), .NSEC(NSEC), .SECW(SECW)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en && wr_ok),
    .wr_sec    (wr_sec),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .copy      (copy),
    .rd_shadow (copy),
    .rd_sec    (nxt_sec),
    .rd_idx    (nxt_idx),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt_state;
  end

  // sec_q/idx_q hold the position of the word currently on the outputs
  always_comb begin
    nxt_state = state;
    nxt_sec   = sec_q;
    nxt_idx   = idx_q;
    nxt_vld   = 1'b0;
    nxt_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          nxt_state = ST_RUN;
          nxt_sec   = '0;
          nxt_idx   = IDX_A1;
          nxt_vld   = 1'b1;
        end
      end
      ST_RUN: begin
        if ((sec_q == LAST_SEC) && (idx_q == IDX_ONE)) begin
          nxt_state = ST_IDLE;
          nxt_sec   = '0;
          nxt_idx   = '0;
        end else begin
          if (idx_q == IDX_ONE) begin
            nxt_sec = sec_q + 1'b1;
            nxt_idx = IDX_A1;
          end else begin
            nxt_idx = idx_q + 3'd1;
          end
          nxt_vld  = 1'b1;
          nxt_done = (nxt_sec == LAST_SEC) && (nxt_idx == IDX_ONE);
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q          <= '0;
      idx_q          <= '0;
      busy           <= 1'b0;
      coef_valid     <= 1'b0;
      coef           <= '0;
      done           <= 1'b0;
      pending_q      <= 1'b0;
      wr_err         <= 1'b0;
    end else begin
      sec_q          <= nxt_vld ? nxt_sec : '0;
      idx_q          <= nxt_vld ? nxt_idx : '0;
      busy           <= (nxt_state == ST_RUN);
      coef_valid     <= nxt_vld;
      coef           <= nxt_vld ? rd_data : '0;
      done           <= nxt_done;
      pending_q      <= (pending_q && !copy) || commit;
      wr_err         <= wr_en && !wr_ok;
    end
  end

  assign coef_sec       = sec_q;
  assign coef_idx       = idx_q;
  assign commit_pending = pending_q;

endmodule

// File: tb/tb_biquad_coef_sequencer.sv
// Scoreboard bench: stimulus pushes the expected word stream per run; a negedge
// monitor pops and compares every presented word including its cycle number.
module tb_biquad_coef_sequencer;

  localparam int WIDTH = 25;
  localparam int FRAC  = 14;
  localparam int NSEC  = 2;
  localparam int SECW  = 3;
  localparam logic [WIDTH-1:0] ONE = 25'd16384;

  logic clk = 1'b0;
  logic reset, start, wr_en, commit;
  logic [SECW-1:0] wr_sec;
  logic [2:0] wr_idx;
  logic signed [WIDTH-1:0] wr_data;
  logic busy, coef_valid, done, commit_pending, wr_err;
  logic [SECW-1:0] coef_sec;
  logic [2:0] coef_idx;
  logic signed [WIDTH-1:0] coef;

  biquad_coef_sequencer #(.WIDTH(WIDTH), .FRAC(FRAC), .NSEC(NSEC), .SECW(SECW)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_en(wr_en), .wr_sec(wr_sec),
    .wr_idx(wr_idx), .wr_data(wr_data), .commit(commit), .busy(busy),
    .coef_valid(coef_valid), .coef_sec(coef_sec), .coef_idx(coef_idx),
    .coef(coef), .done(done), .commit_pending(commit_pending), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [SECW-1:0]  sec;
    logic [2:0]       idx;
    logic [WIDTH-1:0] coef;
    logic             done;
  } word_t;

  word_t q[$];
  int checks = 0, failures = 0, done_cnt = 0;
  bit mon_en = 1'b0;
  logic [WIDTH-1:0] exp_c [NSEC][5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    word_t e, a;
    if (mon_en) begin
      if (coef_valid === 1'b1) begin
        if (done === 1'b1) done_cnt++;
        if (q.size() == 0) begin
          check("unexpected_word", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          a = '{cyc, coef_sec, coef_idx, coef, done};
          checks++;
          if (a !== e) begin
            failures++;
            $display("FAIL word actual cyc=%0d sec=%0d idx=%0d coef=%0d done=%0d required cyc=%0d sec=%0d idx=%0d coef=%0d done=%0d",
                     a.cyc, a.sec, a.idx, $signed(a.coef), a.done,
                     e.cyc, e.sec, e.idx, $signed(e.coef), e.done);
          end
        end
      end else begin
        check("idle_outputs_zero", {31'd0, done | (|coef) | (|coef_sec) | (|coef_idx)}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_identity();
    for (int s = 0; s < NSEC; s++)
      for (int k = 0; k < 5; k++)
        exp_c[s][k] = (k == 2) ? ONE : '0;
  endtask

  task automatic do_start(output int n);
    word_t e;
    n = cyc;
    for (int s = 0; s < NSEC; s++)
      for (int k = 0; k < 6; k++) begin
        e.cyc  = 32'(n + 1 + s * 6 + k);
        e.sec  = SECW'(s);
        e.idx  = 3'(k);
        e.coef = (k == 5) ? ONE : exp_c[s][k];
        e.done = (s == NSEC - 1) && (k == 5);
        q.push_back(e);
      end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q.size() != 0 || busy !== 1'b0) && k < 60) begin
      tick();
      k++;
    end
    check("run_drained", {31'd0, k < 60}, 32'd1);
  endtask

  task automatic write(input int s, input int i, input int d, input bit cm);
    wr_en = 1'b1; wr_sec = SECW'(s); wr_idx = 3'(i); wr_data = WIDTH'(d); commit = cm;
    tick();
    wr_en = 1'b0; commit = 1'b0; wr_sec = '0; wr_idx = '0; wr_data = '0;
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; wr_en = 1'b0; commit = 1'b0;
    wr_sec = '0; wr_idx = '0; wr_data = '0;
    set_identity();
    repeat (3) tick();
    check("rst_coef_valid", {31'd0, coef_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pending", {31'd0, commit_pending}, 32'd0);
    check("rst_wr_err", {31'd0, wr_err}, 32'd0);
    check("rst_coef", 32'(coef), 32'd0);
    reset = 1'b0;
    tick();
    mon_en = 1'b1;

    // identity run and timing edges
    do_start(n);
    wait_until(n + 12);
    check("t12_busy", {31'd0, busy}, 32'd1);
    check("t12_done", {31'd0, done}, 32'd1);
    wait_until(n + 13);
    check("t13_busy", {31'd0, busy}, 32'd0);
    check("t13_valid", {31'd0, coef_valid}, 32'd0);
    wait_idle();

    // idle write + commit
    write(0, 0, 32112, 1'b0);
    write(0, 2, -8, 1'b1);
    check("pend_set", {31'd0, commit_pending}, 32'd1);
    tick();
    check("pend_clear", {31'd0, commit_pending}, 32'd0);
    exp_c[0][0] = 25'd32112;
    exp_c[0][2] = 25'h1FFFFF8;
    do_start(n);
    wait_idle();

    // commit during a run stays pending until idle
    do_start(n);
    wait_until(n + 2);
    write(1, 3, 100, 1'b1);
    wait_until(n + 5);
    check("run_pend_mid", {31'd0, commit_pending}, 32'd1);
    wait_until(n + 12);
    check("run_pend_last", {31'd0, commit_pending}, 32'd1);
    wait_until(n + 13);
    check("run_pend_idle", {31'd0, commit_pending}, 32'd1);
    wait_until(n + 14);
    check("run_pend_clear", {31'd0, commit_pending}, 32'd0);
    wait_idle();
    exp_c[1][3] = 25'd100;
    do_start(n);
    wait_idle();

    // rejected writes
    wr_en = 1'b1; wr_sec = 3'd0; wr_idx = 3'd5; wr_data = 25'd777;
    tick();
    check("wr_err_idx", {31'd0, wr_err}, 32'd1);
    wr_sec = 3'd2; wr_idx = 3'd0; wr_data = 25'd555;
    tick();
    check("wr_err_sec", {31'd0, wr_err}, 32'd1);
    wr_en = 1'b0; wr_sec = '0; wr_idx = '0; wr_data = '0;
    tick();
    check("wr_err_clear", {31'd0, wr_err}, 32'd0);
    commit = 1'b1; tick(); commit = 1'b0;
    tick(); tick();
    do_start(n);
    wait_idle();

    // start during run is ignored
    done_cnt = 0;
    do_start(n);
    wait_until(n + 4);
    start = 1'b1; tick(); start = 1'b0;
    wait_idle();
    repeat (15) tick();
    check("single_done", 32'(done_cnt), 32'd1);

    // reset mid-run aborts, restores identity, drops pending commit
    do_start(n);
    wait_until(n + 2);
    write(0, 1, 4321, 1'b1);
    wait_until(n + 5);
    check("abort_pend_before", {31'd0, commit_pending}, 32'd1);
    reset = 1'b1;
    tick();
    check("abort_valid", {31'd0, coef_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_pend", {31'd0, commit_pending}, 32'd0);
    check("abort_words_left", 32'(q.size()), 32'd7);
    q.delete();
    reset = 1'b0;
    tick();
    set_identity();
    do_start(n);
    wait_idle();
    check("post_rst_pend", {31'd0, commit_pending}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/biquad_coef_sequencer.md
Name: biquad_coef_sequencer

Overview:
- Parametrised successor to the fixed biquad coefficient selector: holds loadable coefficients for NSEC cascaded biquad sections.
- Each section stores five coefficients (a1, a2, b0, b1, b2) plus a constant unity word.
- Coefficients are double-buffered: writes land in a shadow bank, and a commit copies shadow to active only between sample runs.
- On each start pulse, streams every active coefficient in fixed order to the time-multiplexed biquad MAC datapath, one word per cycle.

Parameters:
- WIDTH, 25, coefficient word width, signed two's complement.
- FRAC, 14, fractional bits; unity word ONE = 1 << FRAC.
- NSEC, 2, number of biquad sections (1..8).
- SECW, 3, width of section index fields; must satisfy 2**SECW >= NSEC.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that requests a coefficient run (new sample).
- wr_en  in  1  shadow-bank write strobe.
- wr_sec  in  SECW  section index of the write.
- wr_idx  in  3  coefficient index of the write (0=a1, 1=a2, 2=b0, 3=b1, 4=b2).
- wr_data  in  WIDTH  signed coefficient value.
- commit  in  1  request to copy the shadow bank into the active bank.
- busy  out  1  high while a run is in progress.
- coef_valid  out  1  coef/coef_sec/coef_idx carry a valid word.
- coef_sec  out  SECW  section of the current word.
- coef_idx  out  3  index of the current word (0..5; 5 = unity).
- coef  out  WIDTH  signed coefficient.
- done  out  1  one-cycle pulse coincident with the last valid word.
- commit_pending  out  1  commit requested but not yet applied.
- wr_err  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset values:
  - Active and shadow banks are set to identity for every section: b0 = ONE, all other stored coefficients = 0.
  - All outputs are 0, pending is cleared, and the FSM is in IDLE.
  - Reset during RUN aborts the run immediately; no done pulse is produced.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN when start=1.
  - RUN -> IDLE in the cycle after the last word.
  - start during RUN is ignored; it is not queued.
- Timing for a start sampled in IDLE at cycle t:
  - coef_valid=1 and busy=1 for cycles t+1 .. t+6*NSEC.
  - done=1 at cycle t+6*NSEC.
  - A start at t+6*NSEC+1 is accepted.
- Word order: section 0..NSEC-1 outer, idx 0..5 inner.
  - idx 5 always outputs ONE and is not stored.
  - When coef_valid=0, coef, coef_sec and coef_idx are driven to 0.
- Output registers: all outputs are registered; coef is read from the active bank.
- Shadow writes:
  - Accepted in any state when wr_sec < NSEC and wr_idx <= 4.
  - The shadow bank is updated on the clock edge.
  - A write with wr_idx >= 5 or wr_sec >= NSEC changes nothing and pulses wr_err the next cycle.
- Commit:
  - commit sets commit_pending on the next edge.
  - Whenever the FSM is IDLE and commit_pending=1, the entire shadow bank is copied to active in that single cycle and commit_pending clears.
  - If start arrives in that same IDLE cycle, the start is accepted and the run uses the new coefficients.
  - A commit during RUN stays pending until the first IDLE cycle; the active bank never changes mid-run.
- Simultaneous events:
  - wr_en and commit in the same cycle: the write is included in the copy, because the copy occurs at the earliest one cycle later.
  - commit while already pending has no extra effect.
- No arithmetic is performed; values are stored and forwarded bit-exact.

Decomposition:
- Shared package (biquad_pkg) holds:
  - coefficient index constants IDX_A1=0, IDX_A2=1, IDX_B0=2, IDX_B1=3, IDX_B2=4, IDX_ONE=5;
  - NCOEF_STORED=5 and NCOEF_SEQ=6;
  - FSM state encodings.
- One natural sub-module, coef_bank_dbuf: shadow/active register arrays with write port, copy strobe and read port.
- The FSM and index counters stay in the top level.

Test Plan:
- Reset, then start with NSEC=2 -> 12 valid words at cycles t+1..t+12. Per section the sequence is 0, 0, 16384, 0, 0, 16384. done is high only with word 12. busy falls at t+13.
- Write sec0 a1=32112 and b0=-8 and commit while idle. Then start -> the word at sec0/idx0 = 32112 and sec0/idx2 = -8. commit_pending goes 1 for one cycle, then 0.
- During a run, write sec1 b1=100 and commit -> the rest of the current run still shows 0 at sec1/idx3. commit_pending stays 1 until the first idle cycle. The next run shows 100.
- Write with wr_idx=5, and another with wr_sec=2 (NSEC=2) -> wr_err pulses once for each. The following run is unchanged from the prior run.
- start during RUN at cycle t+4 -> ignored: exactly 12 words and a single done.
- Assert reset at t+5 of a run -> coef_valid, busy and done are 0 from the next edge. Banks return to identity. A previously pending commit is lost.
